// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 data mux. The selected word is
// forwarded on a valid/ready port, and MAX_HOLD bounds the number of beats per grant.
module mux4_rr_arbiter #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  input  logic            out_ready,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic            out_valid,
  output logic [DW-1:0]   dout,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [3:0]      gnt_q;
  logic [1:0]      sel_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] beat_cnt_q;

  logic [1:0] scan_start;
  logic       win_found;
  logic [1:0] win_idx;
  logic       beat;
  logic       rel_grant;

  // Returns {found, index} of the first requester at or after start, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    // On release the scan already starts after the current holder, so no bubble is needed.
    scan_start             = (state_q == StGrant) ? sel_q + 2'd1 : ptr_q;
    {win_found, win_idx}   = rr_pick(req, scan_start);
    busy                   = (state_q == StGrant);
    out_valid              = busy & req[sel_q];
    dout                   = busy ? din[sel_q*DW +: DW] : '0;
    beat                   = out_valid & out_ready;
    rel_grant              = busy & (~req[sel_q] | (beat & (beat_cnt_q == HoldLast)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q    <= StGrant;
            gnt_q      <= 4'b0001 << win_idx;
            sel_q      <= win_idx;
            beat_cnt_q <= '0;
          end
        end
        StGrant: begin
          if (rel_grant) begin
            ptr_q <= sel_q + 2'd1;
            if (win_found) begin
              gnt_q      <= 4'b0001 << win_idx;
              sel_q      <= win_idx;
              beat_cnt_q <= '0;
            end else begin
              // sel keeps its last value while idle
              state_q <= StIdle;
              gnt_q   <= '0;
            end
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule
